// File: rtl/sum_accumulator.sv
// Block accumulator for adder results: sums up to COUNT (WIDTH+1)-bit samples into a
// saturating ACC_WIDTH-bit total and hands each block total out over valid/ready.
module sum_accumulator #(
   parameter int WIDTH     = 4,
   parameter int ACC_WIDTH = 16,
   parameter int COUNT     = 8,
   parameter int CNT_W     = $clog2(COUNT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_sum,
   input  logic                 in_cout,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]     out_cnt,
   output logic                 out_ovf
);

   typedef enum logic [0:0] {S_ACC = 1'b0, S_DONE = 1'b1} state_t;

   localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
   logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
   logic                   out_ovf_q, out_ovf_d;

   logic                   accept;
   logic [ACC_WIDTH:0]     sum_ext;

   // One extra bit catches the carry that signals saturation.
   assign accept  = in_valid & in_ready;
   assign sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH-WIDTH){1'b0}}, in_cout, in_sum};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_cnt_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_cnt_q   <= out_cnt_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_cnt_d   = out_cnt_q;
      out_ovf_d   = out_ovf_q;
      case (state_q)
         S_ACC: begin
            if (accept) begin
               if (sum_ext[ACC_WIDTH]) begin
                  acc_d = '1;
                  ovf_d = 1'b1;
               end else begin
                  acc_d = sum_ext[ACC_WIDTH-1:0];
               end
               cnt_d = cnt_q + CNT_W'(1);
            end
            // Result captures the post-update values, so a sample accepted with flush is included.
            if ((accept && (cnt_d == COUNT_C)) || (flush && (cnt_d != '0))) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               out_data_d  = acc_d;
               out_cnt_d   = cnt_d;
               out_ovf_d   = ovf_d;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_ACC;
               out_valid_d = 1'b0;
               acc_d       = '0;
               cnt_d       = '0;
               ovf_d       = 1'b0;
            end
         end
         default: state_d = S_ACC;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_ACC);
      out_valid = out_valid_q;
      out_data  = out_data_q;
      out_cnt   = out_cnt_q;
      out_ovf   = out_ovf_q;
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 16-bit instance and a 7-bit instance share
// stimulus so the saturating case runs alongside the normal one.
module tb_sum_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_sum;
   logic        in_cout;
   logic        flush;
   logic        out_ready;

   logic        in_ready, out_valid, out_ovf;
   logic [15:0] out_data;
   logic [3:0]  out_cnt;

   logic        in_ready7, out_valid7, out_ovf7;
   logic [6:0]  out_data7;
   logic [3:0]  out_cnt7;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sum_accumulator #(.WIDTH(4), .ACC_WIDTH(16), .COUNT(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_cout(in_cout), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_cnt(out_cnt), .out_ovf(out_ovf)
   );

   sum_accumulator #(.WIDTH(4), .ACC_WIDTH(7), .COUNT(8)) u_dut7 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready7),
      .in_sum(in_sum), .in_cout(in_cout), .flush(flush),
      .out_valid(out_valid7), .out_ready(out_ready),
      .out_data(out_data7), .out_cnt(out_cnt7), .out_ovf(out_ovf7)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Drive n back-to-back samples, then drop in_valid.
   task automatic send(input logic [3:0] s, input logic c, input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_sum   = s;
         in_cout  = c;
         cycle();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; flush = 1'b0; out_ready = 1'b1;
      cycle();
      cycle();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data",  32'(out_data), 0);
      chk("rst_out_cnt",   32'(out_cnt), 0);
      chk("rst_out_ovf",   32'(out_ovf), 0);
      chk("rst_in_ready",  32'(in_ready), 1);
      rst = 1'b0;

      // Full block of eight 31s
      send(4'd15, 1'b1, 8);
      chk("full_valid",   32'(out_valid), 1);
      chk("full_data",    32'(out_data), 248);
      chk("full_cnt",     32'(out_cnt), 8);
      chk("full_ovf",     32'(out_ovf), 0);
      chk("full_ready0",  32'(in_ready), 0);
      chk("sat_data",     32'(out_data7), 127);
      chk("sat_ovf",      32'(out_ovf7), 1);
      chk("sat_cnt",      32'(out_cnt7), 8);
      cycle();
      chk("hs_ready1",    32'(in_ready), 1);
      chk("hs_valid0",    32'(out_valid), 0);
      chk("hs_data_held", 32'(out_data), 248);

      // Block of ones: saturation does not leak into the next block
      send(4'd1, 1'b0, 7);
      chk("ones_not_yet", 32'(out_valid), 0);
      send(4'd1, 1'b0, 1);
      chk("ones_data",    32'(out_data), 8);
      chk("sat2_data",    32'(out_data7), 8);
      chk("sat2_ovf",     32'(out_ovf7), 0);
      cycle();

      // Flush alone after three 5s
      send(4'd5, 1'b0, 3);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_valid",  32'(out_valid), 1);
      chk("flush_data",   32'(out_data), 15);
      chk("flush_cnt",    32'(out_cnt), 3);
      cycle();

      // Flush together with a fourth 5
      send(4'd5, 1'b0, 3);
      in_valid = 1'b1; in_sum = 4'd5; in_cout = 1'b0; flush = 1'b1;
      cycle();
      in_valid = 1'b0; flush = 1'b0;
      chk("flush4_data",  32'(out_data), 20);
      chk("flush4_cnt",   32'(out_cnt), 4);
      cycle();

      // Flush on an empty block is ignored
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush0_valid", 32'(out_valid), 0);
      chk("flush0_ready", 32'(in_ready), 1);

      // Backpressure: result held while samples are offered
      out_ready = 1'b0;
      send(4'd2, 1'b0, 8);
      chk("bp_data",      32'(out_data), 16);
      in_valid = 1'b1; in_sum = 4'd9;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk($sformatf("bp_valid%0d", i), 32'(out_valid), 1);
         chk($sformatf("bp_data%0d", i),  32'(out_data), 16);
         chk($sformatf("bp_cnt%0d", i),   32'(out_cnt), 8);
         chk($sformatf("bp_ready%0d", i), 32'(in_ready), 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      cycle();
      chk("bp_release",   32'(out_valid), 0);
      in_valid = 1'b1; in_sum = 4'd3; flush = 1'b1;
      cycle();
      in_valid = 1'b0; flush = 1'b0;
      chk("bp_fresh_data", 32'(out_data), 3);
      chk("bp_fresh_cnt",  32'(out_cnt), 1);
      cycle();

      // Reset mid-block discards the partial sum
      send(4'd1, 1'b0, 5);
      rst = 1'b1;
      cycle();
      chk("mrst_valid",   32'(out_valid), 0);
      chk("mrst_data",    32'(out_data), 0);
      chk("mrst_cnt",     32'(out_cnt), 0);
      rst = 1'b0;
      cycle();
      chk("mrst_idle",    32'(out_valid), 0);
      chk("mrst_ready",   32'(in_ready), 1);
      send(4'd1, 1'b0, 7);
      chk("mrst_pending", 32'(out_valid), 0);
      send(4'd1, 1'b0, 1);
      chk("mrst_rvalid",  32'(out_valid), 1);
      chk("mrst_rdata",   32'(out_data), 8);
      chk("mrst_rcnt",    32'(out_cnt), 8);
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the adder stage. Takes the adder's per-cycle result `{cout, sum}` as a (WIDTH+1)-bit unsigned sample under a valid/ready handshake. Sums COUNT samples, or fewer if flushed, into an ACC_WIDTH-bit saturating accumulator. Presents each block total on a registered valid/ready output port with sample count and overflow flag.

## Interface
- WIDTH, 4, adder word width; sample is {in_cout, in_sum}, WIDTH+1 bits.
- ACC_WIDTH, 16, accumulator/result width; must be >= WIDTH+1.
- COUNT, 8, samples per block; must be >= 1.
- CNT_W, $clog2(COUNT+1), width of the sample counter and out_cnt (derived).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_sum  in  WIDTH  adder sum.
- in_cout  in  1  adder carry-out (sample MSB).
- flush  in  1  close the current block early.
- out_valid  out  1  block result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_WIDTH  block total, saturated.
- out_cnt  out  CNT_W  number of samples in the block.
- out_ovf  out  1  block total saturated.

## Operation
- Two-state FSM: ACC and DONE.
- Reset:
  - State is ACC.
  - acc=0, cnt=0.
  - out_valid=0, out_data=0, out_cnt=0, out_ovf=0.
- ACC state:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready.
  - On accept: next = acc + zero-extended {in_cout,in_sum}. If next exceeds 2^ACC_WIDTH-1, acc <= all ones and the sticky ovf bit is set. Otherwise acc <= next. cnt <= cnt+1.
- ACC to DONE, either condition:
  - an accept that brings cnt to COUNT;
  - flush=1 with the post-cycle count >= 1.
- On the ACC to DONE transition:
  - Load out_data, out_cnt and out_ovf from the post-update values, including any sample accepted in the same cycle.
  - out_valid <= 1.
- Flush in ACC with cnt=0 and no accept: ignored.
- DONE state:
  - in_ready=0; in_valid and flush are ignored.
  - out_data, out_cnt and out_ovf are held stable.
- DONE to ACC: on out_valid & out_ready.
  - out_valid <= 0; acc, cnt and the sticky ovf bit clear.
  - out_data, out_cnt and out_ovf keep their last values until the next load.
  - in_ready=1 from the following cycle; no same-cycle accept.
- Arithmetic:
  - Unsigned throughout.
  - Saturation is sticky within a block. Later samples leave acc at all ones.
- Reset mid-block or in DONE: partial sum and any pending result are discarded with no output.

## Timing
- in_ready is a function of state only, with no combinational path from in_valid or out_ready.
- All outputs are registered, except in_ready, which is decoded from the state register.
- Latency: result valid the cycle after the accept that completes the block, or after the flush cycle.
- Throughput:
  - one sample per cycle in ACC;
  - at least one bubble cycle per block, the DONE to ACC handoff;
  - best case COUNT+1 cycles per block with out_ready held high.
- out_valid, once high, stays high with stable data until the handshake completes.

## Test plan
- Full block:
  - Stimulus: WIDTH=4, ACC_WIDTH=16, COUNT=8. Eight back-to-back samples in_sum=15, in_cout=1 (31 each). out_ready=1.
  - Response: one cycle after the 8th accept, out_valid=1, out_data=248, out_cnt=8, out_ovf=0. in_ready=0 for exactly one cycle.
- Saturation:
  - Stimulus: ACC_WIDTH=7, same stimulus.
  - Response: out_data=127, out_ovf=1, out_cnt=8. The next block of 8 samples of value 1 gives out_data=8, out_ovf=0.
- Flush:
  - Stimulus: 3 samples of in_sum=5, in_cout=0, then flush=1 alone. Separately, flush together with a 4th sample of 5.
  - Response: flush alone gives out_data=15, out_cnt=3. Flush with the 4th sample gives out_data=20, out_cnt=4. Flush with cnt=0 gives no output.
- Backpressure:
  - Stimulus: complete a block, then hold out_ready=0 for 5 cycles while in_valid=1.
  - Response: out_valid, out_data and out_cnt are stable. in_ready=0 and no samples are counted. After out_ready=1, the next block starts from acc=0.
- Reset mid-block:
  - Stimulus: 5 samples accepted, then rst for 1 cycle, then 8 samples of 1.
  - Response: only one result, out_data=8, out_cnt=8. All outputs read 0 or idle during and right after reset.
